nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor_if.sv | 39 +++
 rtl/nibble_serial_subtractor.sv | 134 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if
//   Bundles the request and result signals of nibble_serial_subtractor.
//   Handshake: a request is accepted on a rising clock edge where start=1
//   and busy=0 (the subtractor is in IDLE or DONE). start raised while busy=1
//   is ignored, not queued. done is a one-cycle pulse. diff, borrow, zero and
//   ovf are valid while done=1 and stay held until the next accepted start.
//   Signals:
//     start      request, sampled only while busy=0
//     a, b, bin  minuend, subtrahend, borrow-in (latched on acceptance)
//     busy       high while nibbles are being processed
//     done       one-cycle completion pulse
//     diff       (a - b - bin) mod 2^16
//     borrow     borrow-out, 1 iff a < b + bin (unsigned)
//     zero, ovf  result flags (0 unless NIBBLE_SUB_FLAGS_EN)
//     state_dbg  current FSM state encoding, observation only
//   Modports: master drives the request, slave is the subtractor.
interface nibble_serial_subtractor_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        zero;
  logic        ovf;
  logic [1:0]  state_dbg;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow, zero, ovf, state_dbg
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow, zero, ovf, state_dbg
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   16-bit subtractor computing diff = a - b - bin, one 4-bit nibble per
//   clock, least significant nibble first, with a registered borrow chain.
//   A start accepted at edge E0 gives busy for four cycles and a done pulse
//   after E4. Holding start high through the DONE cycle chains the next
//   operation with no idle cycle.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  nibble_serial_subtractor_if.slave (request, result, state_dbg)
//   Configuration:
//     NIBBLE_SUB_FLAGS_EN  when defined, zero and ovf are computed and
//                          registered with the final nibble; otherwise they
//                          are tied to 0 and no flag logic exists.
module nibble_serial_subtractor (
  input  logic                          clk,
  input  logic                          rst,
  nibble_serial_subtractor_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        br_q;
  logic [1:0]  n_q;
  logic [15:0] diff_q;
  logic        borrow_q;

  logic        accept;
  logic        last_nib;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  t;
  logic [15:0] diff_next;

  // A request is taken in IDLE and also in DONE, which gives back-to-back
  // operation when start is held high.
  assign accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_nib = (n_q == 2'd3);

  // Nibble slice and 5-bit subtract; t[4] is the borrow into the next nibble.
  assign a_nib = a_q[{n_q, 2'b00} +: 4];
  assign b_nib = b_q[{n_q, 2'b00} +: 4];
  assign t     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, br_q};

  always_comb begin
    diff_next = diff_q;
    diff_next[{n_q, 2'b00} +: 4] = t[3:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (last_nib) state_d = S_DONE;
      S_DONE: state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latches, borrow chain, nibble index and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      br_q     <= 1'b0;
      n_q      <= 2'd0;
      diff_q   <= 16'h0000;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      br_q <= bus.bin;
      n_q  <= 2'd0;
    end else if (state_q == S_RUN) begin
      diff_q <= diff_next;
      br_q   <= t[4];
      n_q    <= n_q + 2'd1;
      if (last_nib) begin
        borrow_q <= t[4];
      end
    end
  end

`ifdef NIBBLE_SUB_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Flags are taken from the completed result in the same edge that writes
  // the top nibble, so they use diff_next rather than diff_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if ((state_q == S_RUN) && last_nib && !accept) begin
      zero_q <= (diff_next == 16'h0000);
      ovf_q  <= (a_q[15] != b_q[15]) && (diff_next[15] != a_q[15]);
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  // busy and done decode the state register only; no input reaches an
  // output without passing through a flop.
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor
//   Self-checking bench for nibble_serial_subtractor: directed cases,
//   back-to-back operation, asynchronous reset mid-run and randomized
//   operands compared against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  localparam int W = 19; // {ovf, zero, borrow, diff}

  logic clk;
  logic rst;

  nibble_serial_subtractor_if bus ();

  nibble_serial_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the whole 16-bit words.
  function automatic logic [W-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic bin);
    int          ua;
    int          ub;
    int          sa;
    int          sb;
    int          sr;
    int          d;
    logic [31:0] dv;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
    ua     = int'(a);
    ub     = int'(b);
    d      = ua - ub - int'(bin);
    dv     = d;
    diff   = dv[15:0];
    borrow = (ua < ub + int'(bin));
    sa     = int'($signed(a));
    sb     = int'($signed(b));
    sr     = sa - sb - int'(bin);
`ifdef NIBBLE_SUB_FLAGS_EN
    zero   = (diff == 16'h0000);
    ovf    = (sr < -32768) || (sr > 32767);
`else
    zero   = 1'b0;
    ovf    = 1'b0;
`endif
    return {ovf, zero, borrow, diff};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_result(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_diff"},   32'(bus.diff),   32'(e[15:0]));
      check({tag, "_borrow"}, 32'(bus.borrow), 32'(e[16]));
      check({tag, "_zero"},   32'(bus.zero),   32'(e[17]));
      check({tag, "_ovf"},    32'(bus.ovf),    32'(e[18]));
    end
  endtask

  // ---------------- drivers ----------------
  // Single operation from IDLE; scrambles operands after acceptance and
  // pulses start mid-run, both of which must be ignored.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    exp_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.bin   = 1'($urandom_range(0, 1));
    check({tag, "_busy_e0"}, 32'(bus.busy), 1);
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a     = 16'($urandom);
      end
      if (k == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(k + 1), 5);
        check({tag, "_busy_done"}, 32'(bus.busy), 0);
        check_result(tag);
      end else begin
        check({tag, "_busy_run"}, 32'(bus.busy), 1);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    if (!seen && exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] held_diff;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    bit          any_done;
    bit          seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    bus.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(bus.busy),   0);
    check("rst_done",   32'(bus.done),   0);
    check("rst_diff",   32'(bus.diff),   0);
    check("rst_borrow", 32'(bus.borrow), 0);
    check("rst_zero",   32'(bus.zero),   0);
    check("rst_ovf",    32'(bus.ovf),    0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_op("d1", 16'h1234, 16'h0234, 1'b0);
    do_op("d2", 16'h0000, 16'h0001, 1'b0);
    do_op("d3", 16'h8000, 16'h0001, 1'b0);
    do_op("d4", 16'h0005, 16'h0004, 1'b1);
    do_op("d5", 16'hFFFF, 16'hFFFF, 1'b1);
    do_op("d6", 16'h7FFF, 16'hFFFF, 1'b0);

    // Result holds through IDLE.
    held_diff = bus.diff;
    repeat (3) @(posedge clk);
    #1;
    check("hold_diff", 32'(bus.diff), 32'(model(16'h7FFF, 16'hFFFF, 1'b0) & 19'h0FFFF));
    check("hold_idle_busy", 32'(bus.busy), 0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    exp_q.push_back(model(16'hFFFF, 16'h0001, 1'b0));
    exp_q.push_back(model(16'h0100, 16'h0001, 1'b0));
    @(posedge clk); #1;
    for (int op = 0; op < 2; op++) begin
      for (int k = 1; k <= 4; k++) begin
        check("b2b_busy", 32'(bus.busy), 1);
        check("b2b_nodone", 32'(bus.done), 0);
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        @(posedge clk); #1;
      end
      check("b2b_done", 32'(bus.done), 1);
      check("b2b_busy_low", 32'(bus.busy), 0);
      check_result("b2b");
      if (op == 0) begin
        bus.a   = 16'h0100;
        bus.b   = 16'h0001;
        bus.bin = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_busy", 32'(bus.busy), 0);
    check("b2b_idle_done", 32'(bus.done), 0);

    // Asynchronous reset mid-run, after nibble 2.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1357;
    bus.b     = 16'h2468;
    bus.bin   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",   32'(bus.busy),   0);
    check("arst_done",   32'(bus.done),   0);
    check("arst_diff",   32'(bus.diff),   0);
    check("arst_borrow", 32'(bus.borrow), 0);
    check("arst_zero",   32'(bus.zero),   0);
    check("arst_ovf",    32'(bus.ovf),    0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done) any_done = 1'b1;
    end
    check("arst_no_done", 32'(any_done), 0);
    do_op("post_rst", 16'h0003, 16'h0007, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      do_op("rnd", ra, rb, rbin);
    end

    // Random back-to-back chain.
    seen = 1'b1;
    for (int i = 0; i < 10 && seen; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ra;
      bus.b     = rb;
      bus.bin   = rbin;
      exp_q.push_back(model(ra, rb, rbin));
      @(posedge clk); #1;
      bus.start = (i < 9);
      seen = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          seen = 1'b1;
          check("chain_latency", 32'(k + 1), 5);
          check_result("chain");
        end
      end
      check("chain_done_seen", 32'(seen), 1);
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
